// File: rtl/freq_counter_pkg.sv
// Shared definitions for the DS1086L frequency counter: FSM states and the
// bit positions of the GPIO control and result words.
package freq_counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   // ctrl_i fields (driven by GPIO_IO_O)
   localparam int EN       = 0;
   localparam int START    = 1;
   localparam int CONT     = 2;
   localparam int GATE_LSB = 4;

   // result_o fields (read back on GPIO_IO_I)
   localparam int OVF   = 28;
   localparam int BUSY  = 29;
   localparam int VALID = 30;
   localparam int SEQ   = 31;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a
// rising-edge detector producing a one-cycle pulse in the local clock domain.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ds1086_freq_counter.sv
// Gated edge counter measuring the DS1086L output against GCLK; control and
// results are exchanged with firmware through axi_gpio_6.
module ds1086_freq_counter
   import freq_counter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int GATE_W      = 24,
   parameter int CNT_W       = 28
) (
   input  logic        GCLK,
   input  logic        RESET,
   input  logic        meas_clk_i,
   input  logic [31:0] ctrl_i,
   output logic [31:0] result_o
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

   state_t              state;
   logic                start_q;
   logic                start_pulse;
   logic                en;
   logic                cont;
   logic [GATE_W-1:0]   gate_len;
   logic [GATE_W-1:0]   gate_cnt;
   logic [CNT_W-1:0]    edge_cnt;
   logic                ovf;
   logic [CNT_W-1:0]    cnt_res;
   logic                ovf_res;
   logic                busy_q;
   logic                valid_q;
   logic                seq_q;
   logic                rise;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   assign en          = ctrl_i[EN];
   assign cont        = ctrl_i[CONT];
   assign gate_len    = ctrl_i[GATE_LSB +: GATE_W];
   assign start_pulse = ctrl_i[START] & ~start_q;

   generate
      if (GATE_LSB + GATE_W < 32) begin : g_unused_hi
         logic unused_ctrl;
         assign unused_ctrl = ^{ctrl_i[31:GATE_LSB+GATE_W], ctrl_i[3]};
      end else begin : g_unused_lo
         logic unused_ctrl;
         assign unused_ctrl = ctrl_i[3];
      end
   endgenerate

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (GCLK),
      .rst  (RESET),
      .din  (meas_clk_i),
      .rise (rise)
   );

   always_ff @(posedge GCLK) begin
      if (RESET) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
         cnt_res  <= '0;
         ovf_res  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         seq_q    <= 1'b0;
      end else begin
         start_q <= ctrl_i[START];
         busy_q  <= (state != IDLE);
         case (state)
            IDLE: begin
               if (en && (start_pulse || cont)) begin
                  state    <= GATE;
                  gate_cnt <= (gate_len == '0) ? GATE_ONE : gate_len;
                  edge_cnt <= '0;
                  ovf      <= 1'b0;
               end
            end
            GATE: begin
               // Abort takes priority over the final gate cycle.
               if (!en) begin
                  state <= IDLE;
               end else begin
                  if (rise) begin
                     if (edge_cnt == CNT_MAX)
                        ovf <= 1'b1;
                     edge_cnt <= sat_inc(edge_cnt);
                  end
                  gate_cnt <= gate_cnt - GATE_ONE;
                  if (gate_cnt == GATE_ONE)
                     state <= LATCH;
               end
            end
            LATCH: begin
               cnt_res <= edge_cnt;
               ovf_res <= ovf;
               valid_q <= 1'b1;
               seq_q   <= ~seq_q;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      result_o              = '0;
      result_o[CNT_W-1:0]   = cnt_res;
      result_o[OVF]         = ovf_res;
      result_o[BUSY]        = busy_q;
      result_o[VALID]       = valid_q;
      result_o[SEQ]         = seq_q;
   end

endmodule

// File: tb/tb_ds1086_freq_counter.sv
// Bench for ds1086_freq_counter: two instances (wide and narrow counter)
// share stimulus and are checked against a sample-history model.
module tb_ds1086_freq_counter;

   localparam int SA  = 2;
   localparam int CWA = 28;
   localparam int SB  = 3;
   localparam int CWB = 4;
   localparam logic [31:0] BUSYB = 32'h2000_0000;

   logic        GCLK = 1'b0;
   logic        RESET;
   logic        meas_clk_i = 1'b0;
   logic [31:0] ctrl_i;
   logic [31:0] res_a;
   logic [31:0] res_b;

   int total = 0;
   int bad   = 0;

   always #5 GCLK = ~GCLK;

   ds1086_freq_counter #(.SYNC_STAGES(SA), .GATE_W(24), .CNT_W(CWA)) u_dut (
      .GCLK(GCLK), .RESET(RESET), .meas_clk_i(meas_clk_i), .ctrl_i(ctrl_i), .result_o(res_a)
   );

   ds1086_freq_counter #(.SYNC_STAGES(SB), .GATE_W(24), .CNT_W(CWB)) u_sat (
      .GCLK(GCLK), .RESET(RESET), .meas_clk_i(meas_clk_i), .ctrl_i(ctrl_i), .result_o(res_b)
   );

   // Pin value as seen at every rising GCLK edge, indexed by edge number.
   bit hist [0:65535];
   int ecnt = 0;
   always @(posedge GCLK) begin
      hist[ecnt] = meas_clk_i;
      ecnt = ecnt + 1;
   end

   // Stimulus source for meas_clk_i: square wave of period per, a held level, or random bits.
   int per = 0;
   int ph = 0;
   bit rnd_mode = 1'b0;
   bit level = 1'b0;
   always @(negedge GCLK) begin
      if (rnd_mode)
         meas_clk_i <= 1'($urandom_range(0, 1));
      else if (per == 0)
         meas_clk_i <= level;
      else begin
         ph = (ph + 1) % per;
         meas_clk_i <= (ph < per / 2);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge GCLK);
         #1;
      end
   endtask

   function automatic logic [31:0] make_ctrl(input bit en, input bit st, input bit cont, input int n);
      logic [31:0] c;
      c = '0;
      c[0] = en;
      c[1] = st;
      c[2] = cont;
      c[27:4] = n[23:0];
      return c;
   endfunction

   // Rising edges on the pin that a gate seen-start at edge t and lasting n edges
   // counts, given the s-edge synchronizer delay.
   function automatic int raw_edges(input int t, input int n, input int s);
      int cnt;
      cnt = 0;
      for (int e = t + 1; e <= t + n; e++)
         if (!hist[e - s - 1] && hist[e - s]) cnt++;
      return cnt;
   endfunction

   function automatic logic [31:0] word(input int raw, input int cw, input bit seq);
      int mx;
      logic [31:0] w;
      mx = (1 << cw) - 1;
      w = '0;
      w[27:0] = 28'((raw > mx) ? mx : raw);
      w[28] = (raw > mx);
      w[30] = 1'b1;
      w[31] = seq;
      return w;
   endfunction

   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;
   bit exp_seq = 1'b0;

   task automatic latch_expect(input int t, input int ne);
      exp_seq = ~exp_seq;
      last_a = word(raw_edges(t, ne, SA), CWA, exp_seq);
      last_b = word(raw_edges(t, ne, SB), CWB, exp_seq);
   endtask

   // Single-shot: start first seen at edge t, result checked right after edge t+N+1.
   task automatic measure(input int n, input string tag);
      int t;
      int ne;
      ne = (n == 0) ? 1 : n;
      ctrl_i = make_ctrl(1'b1, 1'b1, 1'b0, n);
      t = ecnt;
      tick(1);
      chk({tag, "_idle_a"}, res_a, last_a);
      tick(1);
      chk({tag, "_busy_a"}, res_a, last_a | BUSYB);
      tick(ne - 1);
      chk({tag, "_pre_a"}, res_a, last_a | BUSYB);
      tick(1);
      latch_expect(t, ne);
      chk({tag, "_res_a"}, res_a, last_a | BUSYB);
      chk({tag, "_res_b"}, res_b, last_b | BUSYB);
      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, n);
      tick(1);
      chk({tag, "_done_a"}, res_a, last_a);
      chk({tag, "_done_b"}, res_b, last_b);
      tick(3);
   endtask

   initial begin
      int t;
      RESET = 1'b1;
      ctrl_i = '0;
      tick(4);
      chk("reset_a", res_a, 32'h0);
      chk("reset_b", res_b, 32'h0);
      RESET = 1'b0;
      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, 0);
      tick(8);

      per = 10;
      measure(1000, "basic");

      per = 0;
      level = 1'b1;
      tick(8);
      measure(0, "zero_gate");

      per = 4;
      tick(4);
      measure(100, "sat");

      for (int i = 0; i < 10; i++) begin
         rnd_mode = ($urandom_range(0, 2) == 0);
         per = $urandom_range(2, 12);
         measure($urandom_range(0, 80), "rand");
      end
      rnd_mode = 1'b0;

      // Known reference result before the abort cases.
      per = 10;
      measure(1000, "pre_abort");

      ctrl_i = make_ctrl(1'b1, 1'b1, 1'b0, 600);
      tick(500);
      ctrl_i = make_ctrl(1'b0, 1'b0, 1'b0, 600);
      tick(1);
      chk("abort_busy_hold", res_a, last_a | BUSYB);
      tick(1);
      chk("abort_idle_a", res_a, last_a);
      tick(200);
      chk("abort_keep_a", res_a, last_a);
      chk("abort_keep_b", res_b, last_b);

      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, 20);
      tick(4);
      ctrl_i = make_ctrl(1'b1, 1'b1, 1'b0, 20);
      tick(20);
      ctrl_i = make_ctrl(1'b0, 1'b0, 1'b0, 20);
      tick(2);
      chk("abort_last_a", res_a, last_a);
      tick(3);
      chk("abort_last_keep_b", res_b, last_b);

      // Continuous: one result every N+2 cycles until continuous is cleared mid-gate.
      per = 5;
      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b1, 50);
      t = ecnt;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            tick(3);
            ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, 50);
            tick(49);
         end else begin
            tick(52);
         end
         latch_expect(t + k * 52, 50);
         chk("cont_res_a", res_a, last_a | BUSYB);
         chk("cont_res_b", res_b, last_b | BUSYB);
      end
      tick(60);
      chk("cont_stop_a", res_a, last_a);

      // Start held high for 300 cycles gives exactly one measurement.
      per = 7;
      ctrl_i = make_ctrl(1'b1, 1'b1, 1'b0, 100);
      t = ecnt;
      tick(102);
      latch_expect(t, 100);
      chk("held_res_a", res_a, last_a | BUSYB);
      tick(198);
      chk("held_once_a", res_a, last_a);
      chk("held_once_b", res_b, last_b);
      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, 100);
      tick(2);

      // Reset in the middle of a gate.
      ctrl_i = make_ctrl(1'b1, 1'b1, 1'b0, 200);
      tick(50);
      RESET = 1'b1;
      ctrl_i = make_ctrl(1'b1, 1'b0, 1'b0, 200);
      tick(1);
      chk("midreset_a", res_a, 32'h0);
      chk("midreset_b", res_b, 32'h0);
      RESET = 1'b0;
      last_a = '0;
      last_b = '0;
      exp_seq = 1'b0;
      tick(10);
      chk("postreset_idle_a", res_a, 32'h0);
      measure(30, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
